// File: rtl/spi_reg_bank.sv
// ============================================================================
// spi_reg_bank
//
// SPI mode-0 peripheral register bank running entirely on the system clock.
// The SPI pins are synchronised and edge-detected; sclk and ncs are never used
// as clocks. A frame is 1 + ADDR_W + DATA_W bits, MSB first:
//   R/W (1 = write) | address | data
// A write frame of the exact length updates one register when ncs rises.
// A frame of any other non-zero length is discarded and frame_err pulses.
//
// Optional feature macro: SPI_READBACK_EN
//   defined   : read frames drive the addressed register onto cipo, MSB first.
//   undefined : cipo and cipo_oe are tied low and the readback path is absent.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   sclk       SPI clock (asynchronous to clk)
//   ncs        SPI chip select, active low (asynchronous)
//   copi       SPI controller-out data (asynchronous)
//   cipo       SPI peripheral-out data
//   cipo_oe    output enable for the cipo pad
//   reg_out    register contents, register i at [i*DATA_W +: DATA_W]
//   wr_strobe  one-clk pulse on the cycle register i is updated
//   frame_err  one-clk pulse when a frame is discarded for bad length
// ============================================================================
module spi_reg_bank #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Pin synchronisers: bit 0 = sclk, bit 1 = ncs, bit 2 = copi.
    // The chains reset to 0. For ncs this means "not yet seen high", so a chip
    // select that is already low when reset is released cannot look like a
    // falling edge; the bank only arms once ncs has been high.
    // ------------------------------------------------------------------------
    logic [2:0] pin_raw;
    logic [2:0] pin_s;

    assign pin_raw = {copi, ncs, sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_raw[gi]};
                end
            end

            assign pin_s[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    // Extra flop on sclk and ncs for edge detection.
    logic [1:0] prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= pin_s[1:0];
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic ncs_rise;
    logic ncs_fall;
    logic copi_s;

    assign sclk_rise = pin_s[0] & ~prev_reg[0];
    assign sclk_fall = ~pin_s[0] & prev_reg[0];
    assign ncs_rise  = pin_s[1] & ~prev_reg[1];
    assign ncs_fall  = ~pin_s[1] & prev_reg[1];
    assign copi_s    = pin_s[2];

    // ------------------------------------------------------------------------
    // Frame FSM and shift path
    // ------------------------------------------------------------------------
    state_t              state_reg,  state_next;
    logic [CNT_W-1:0]    count_reg,  count_next;
    logic [FRAME_W-1:0]  shift_reg,  shift_next;
    logic [NUM_REGS-1:0] wr_en_reg,  wr_en_next;
    logic                err_pend_reg, err_next;
    logic [DATA_W-1:0]   wr_data_reg;
    logic [ADDR_W-1:0]   frame_addr;

    assign frame_addr = shift_reg[FRAME_W-2 -: ADDR_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_next = shift_reg;
        wr_en_next = '0;
        err_next   = 1'b0;

        if (state_reg == IDLE) begin
            // sclk activity while deselected is ignored here.
            if (ncs_fall) begin
                state_next = CMD;
                count_next = '0;
                shift_next = '0;
            end
        end else if (ncs_rise) begin
            // End of frame: decide the outcome now, apply it one cycle later.
            state_next = IDLE;
            if (count_reg == CNT_FULL) begin
                if (shift_reg[FRAME_W-1]) begin
                    // Unimplemented addresses match no enable and are dropped.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (frame_addr == ADDR_W'(i)) begin
                            wr_en_next[i] = 1'b1;
                        end
                    end
                end
            end else if (count_reg != '0) begin
                err_next = 1'b1;
            end
        end else if (sclk_rise) begin
            shift_next = {shift_reg[FRAME_W-2:0], copi_s};
            // Saturate one past a full frame so over-long frames stay invalid.
            if (count_reg != CNT_SAT) begin
                count_next = count_reg + 1'b1;
            end
            if ((state_reg == CMD) && (count_reg == CNT_ADDR_LAST)) begin
                state_next = shift_next[ADDR_W] ? WR_DATA : RD_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg    <= '0;
            shift_reg    <= '0;
            wr_en_reg    <= '0;
            err_pend_reg <= 1'b0;
            wr_data_reg  <= '0;
        end else begin
            count_reg    <= count_next;
            shift_reg    <= shift_next;
            wr_en_reg    <= wr_en_next;
            err_pend_reg <= err_next;
            wr_data_reg  <= shift_reg[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Register storage and strobes. The write lands on the cycle after the
    // ncs rise is seen, together with its strobe.
    // ------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (wr_en_reg[gi]) begin
                    data_reg <= wr_data_reg;
                end
            end

            assign reg_out[gi*DATA_W +: DATA_W] = data_reg;
        end
    endgenerate

    logic [NUM_REGS-1:0] wr_strobe_reg;
    logic                frame_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_strobe_reg <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            wr_strobe_reg <= wr_en_reg;
            frame_err_reg <= err_pend_reg;
        end
    end

    assign wr_strobe = wr_strobe_reg;
    assign frame_err = frame_err_reg;

    // ------------------------------------------------------------------------
    // Readback
    // ------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
    logic              cipo_reg,    cipo_next;
    logic              cipo_oe_reg;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic [DATA_W-1:0] rd_lookup;

    always_comb begin
        // Address is complete in shift_next on the last address-bit rise.
        rd_lookup = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_next[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_lookup = reg_out[i*DATA_W +: DATA_W];
            end
        end

        rd_data_next = rd_data_reg;
        cipo_next    = cipo_reg;

        if ((state_reg == CMD) && (state_next == RD_DATA)) begin
            // Present the MSB immediately so it is valid before the first
            // data-phase rise.
            rd_data_next = rd_lookup;
            cipo_next    = rd_lookup[DATA_W-1];
        end else if ((state_reg == RD_DATA) && sclk_fall) begin
            // Select by bit count rather than shifting: the fall that follows
            // the last address rise must re-present the MSB, not advance.
            cipo_next = 1'b0;
            for (int j = 0; j < DATA_W; j++) begin
                if (count_reg == CNT_W'(1 + ADDR_W + j)) begin
                    cipo_next = rd_data_reg[DATA_W-1-j];
                end
            end
        end

        if (state_next != RD_DATA) begin
            cipo_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cipo_reg    <= 1'b0;
            cipo_oe_reg <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            cipo_reg    <= cipo_next;
            cipo_oe_reg <= (state_next == RD_DATA);
            rd_data_reg <= rd_data_next;
        end
    end

    assign cipo    = cipo_reg;
    assign cipo_oe = cipo_oe_reg;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 7;
    localparam int NUM_REGS    = 5;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_BITS  = 1 + ADDR_W + DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic ncs   = 1'b1;
    logic copi  = 1'b0;
    logic                       cipo;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] reg_out;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       frame_err;

    always #5 clk = ~clk;

    spi_reg_bank #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .reg_out   (reg_out),
        .wr_strobe (wr_strobe),
        .frame_err (frame_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model state
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    bit                pend_valid = 0;
    int                pend_cycle = 0;
    bit                pend_wr    = 0;
    int                pend_addr  = 0;
    logic [DATA_W-1:0] pend_data  = '0;
    bit                pend_err   = 0;

    int strobe_count   = 0;
    int err_count      = 0;
    int last_strobe_cyc = 0;
    int rise_cyc       = 0;

    logic cap_cipo [32];
    logic cap_oe   [32];

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Compare process: applies scheduled frame outcomes to the model on the
    // predicted cycle and checks all register-side outputs every cycle.
    // ------------------------------------------------------------------------
    initial begin
        logic                       rst_sample;
        logic [NUM_REGS-1:0]        exp_strobe;
        logic                       exp_err;
        logic [NUM_REGS*DATA_W-1:0] exp_out;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        forever begin
            @(posedge clk);
            rst_sample = rst_n;
            #1;
            cyc++;
            exp_strobe = '0;
            exp_err    = 1'b0;
            if (!rst_sample) begin
                for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
                pend_valid = 0;
            end else if (pend_valid && cyc == pend_cycle) begin
                pend_valid = 0;
                if (pend_wr) begin
                    m_regs[pend_addr]     = pend_data;
                    exp_strobe[pend_addr] = 1'b1;
                end
                exp_err = pend_err;
            end
            for (int i = 0; i < NUM_REGS; i++) exp_out[i*DATA_W +: DATA_W] = m_regs[i];
            check_val("reg_out", 64'(reg_out), 64'(exp_out));
            check_val("wr_strobe", 64'(wr_strobe), 64'(exp_strobe));
            check_val("frame_err", 64'(frame_err), 64'(exp_err));
`ifndef SPI_READBACK_EN
            check_val("cipo_tied", 64'(cipo), 64'd0);
            check_val("cipo_oe_tied", 64'(cipo_oe), 64'd0);
`endif
            if (wr_strobe != '0) begin
                strobe_count++;
                last_strobe_cyc = cyc;
            end
            if (frame_err) err_count++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends bits[hi] down to bits[lo]; samples cipo/cipo_oe just before each rise.
    task automatic shift_bits(input logic [31:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            copi = bits[i];
            wait_clks($urandom_range(5, 8));
            cap_cipo[i] = cipo;
            cap_oe[i]   = cipo_oe;
            sclk = 1'b1;
            wait_clks($urandom_range(5, 8));
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits);
        logic              rw;
        int                addr;
        logic [DATA_W-1:0] dat;
        logic [DATA_W-1:0] rd_exp;
        rw     = bits[FRAME_BITS-1];
        addr   = int'(bits[FRAME_BITS-2 -: ADDR_W]);
        dat    = bits[DATA_W-1:0];
        rd_exp = (addr < NUM_REGS) ? m_regs[addr] : '0;

        ncs = 1'b0;
        wait_clks(6);
        if (nbits > 0) shift_bits(bits, nbits - 1, 0);
        wait_clks(6);
        ncs = 1'b1;
        rise_cyc = cyc;

        pend_wr  = 0;
        pend_err = 0;
        if (nbits == FRAME_BITS) begin
            if (rw && addr < NUM_REGS) begin
                pend_wr   = 1;
                pend_addr = addr;
                pend_data = dat;
            end
        end else if (nbits != 0) begin
            pend_err = 1;
        end
        pend_cycle = cyc + SYNC_STAGES + 2;
        pend_valid = pend_wr || pend_err;
        wait_clks(12);

`ifdef SPI_READBACK_EN
        if (nbits == FRAME_BITS && !rw) begin
            for (int i = DATA_W - 1; i >= 0; i--) begin
                check_val("rd_cipo_bit", 64'(cap_cipo[i]), 64'(rd_exp[i]));
                check_val("rd_oe_data", 64'(cap_oe[i]), 64'd1);
            end
            check_val("rd_oe_cmd", 64'(cap_oe[FRAME_BITS-1]), 64'd0);
            check_val("rd_oe_after", 64'(cipo_oe), 64'd0);
        end
`else
        if (rd_exp == '1) $display("note: readback disabled, value %0h not driven", rd_exp);
`endif
    endtask

    initial begin
        int              s0, e0;
        logic [31:0]     bits;
        int              nbits;
        int              r;
        logic [DATA_W-1:0] rd_byte;

        rst_n = 1'b0;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(5);

        check_val("reset_reg_out", 64'(reg_out), 64'd0);
        check_val("reset_cipo", 64'(cipo), 64'd0);
        check_val("reset_cipo_oe", 64'(cipo_oe), 64'd0);

        // Write reg0 = F0; strobe once, 4 clk after raw ncs rise.
        send_frame(32'h80F0, 16);
        check_val("w80F0_reg0", 64'(reg_out[7:0]), 64'hF0);
        check_val("w80F0_others", 64'(reg_out[39:8]), 64'd0);
        check_val("w80F0_strobes", 64'(strobe_count), 64'd1);
        check_val("w80F0_latency", 64'(last_strobe_cyc - rise_cyc), 64'd4);

        send_frame(32'h84A5, 16);
        check_val("w84A5_reg4", 64'(reg_out[39:32]), 64'hA5);
        check_val("w84A5_strobes", 64'(strobe_count), 64'd2);
        send_frame(32'h8400, 16);
        check_val("w8400_reg4", 64'(reg_out[39:32]), 64'h00);
        check_val("w8400_strobes", 64'(strobe_count), 64'd3);

        // Out-of-range address: silently dropped.
        send_frame(32'h8555, 16);
        check_val("w8555_regs", 64'(reg_out), 64'h00000000F0);
        check_val("w8555_strobes", 64'(strobe_count), 64'd3);
        check_val("w8555_err", 64'(err_count), 64'd0);

        // Short and long frames.
        send_frame(32'h080F, 12);
        check_val("short_err", 64'(err_count), 64'd1);
        send_frame(32'h101E1, 17);
        check_val("long_err", 64'(err_count), 64'd2);
        check_val("len_reg0", 64'(reg_out[7:0]), 64'hF0);

        // Empty frame: no error.
        send_frame(32'h0, 0);
        check_val("empty_err", 64'(err_count), 64'd2);

        // Read of reg4 = A5.
        send_frame(32'h84A5, 16);
        s0 = strobe_count;
        e0 = err_count;
        send_frame(32'h0400, 16);
        check_val("read_no_strobe", 64'(strobe_count), 64'(s0));
        check_val("read_no_err", 64'(err_count), 64'(e0));
        check_val("read_reg4", 64'(reg_out[39:32]), 64'hA5);
`ifdef SPI_READBACK_EN
        for (int i = 0; i < DATA_W; i++) rd_byte[i] = cap_cipo[i];
        check_val("read_A5_literal", 64'(rd_byte), 64'hA5);
`else
        rd_byte = '0;
        check_val("read_disabled_cipo", 64'(cipo), 64'(rd_byte));
`endif

        // Reset mid-frame with ncs held low.
        s0 = strobe_count;
        e0 = err_count;
        ncs = 1'b0;
        wait_clks(6);
        shift_bits(32'h80F0, 15, 8);
        rst_n = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(3);
        check_val("midrst_regs", 64'(reg_out), 64'd0);
        shift_bits(32'h80F0, 7, 0);
        wait_clks(6);
        ncs = 1'b1;
        wait_clks(12);
        check_val("midrst_regs_after", 64'(reg_out), 64'd0);
        check_val("midrst_no_strobe", 64'(strobe_count), 64'(s0));
        check_val("midrst_no_err", 64'(err_count), 64'(e0));
        send_frame(32'h8133, 16);
        check_val("w8133_reg1", 64'(reg_out[15:8]), 64'h33);

        // Randomised frames against the model.
        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 6) begin
                nbits = FRAME_BITS;
                bits  = {16'h0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                         7'($urandom_range(0, 7)), 8'($urandom)};
            end else if (r == 7) begin
                nbits = 0;
                bits  = '0;
            end else if (r == 8) begin
                nbits = $urandom_range(1, 15);
                bits  = $urandom;
            end else begin
                nbits = $urandom_range(17, 22);
                bits  = $urandom;
            end
            send_frame(bits, nbits);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
